// File: rtl/alu_operand_sequencer.sv
// Operand fetch / writeback stage wrapped around a combinational ALU.
// Owns the register file and runs one instruction at a time (IDLE -> EXEC -> WB).
module alu_operand_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned NREG   = 8,
  localparam int unsigned AW      = $clog2(NREG),
  localparam int unsigned INSTR_W = OP_W + 3 * AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [OP_W-1:0]    alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_f,
  output logic               res_valid,
  output logic [AW-1:0]      res_rd,
  output logic [DATA_W-1:0]  res_data,
  input  logic               ld_en,
  input  logic [AW-1:0]      ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic [AW-1:0]      dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_capture;
  logic                w_wb;

  logic [DATA_W-1:0]   r_regs [NREG];
  logic [AW-1:0]       r_rd;

  logic [OP_W-1:0]     w_op;
  logic [AW-1:0]       w_rd;
  logic [AW-1:0]       w_rs1;
  logic [AW-1:0]       w_rs2;

  assign w_op  = in_instr[INSTR_W-1 -: OP_W];
  assign w_rd  = in_instr[3*AW-1 -: AW];
  assign w_rs1 = in_instr[2*AW-1 -: AW];
  assign w_rs2 = in_instr[AW-1:0];

  assign in_ready = (r_state == S_IDLE) && !rst;
  assign dbg_data = r_regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        w_wb        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // res_data doubles as the captured ALU result that WB commits to the regfile.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_valid <= 1'b0;
      res_rd    <= '0;
      res_data  <= '0;
      r_rd      <= '0;
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else begin
      res_valid <= 1'b0;
      if (w_accept) begin
        alu_op <= w_op;
        alu_a  <= r_regs[w_rs1];
        alu_b  <= r_regs[w_rs2];
        r_rd   <= w_rd;
      end
      if (w_capture) begin
        res_valid <= 1'b1;
        res_rd    <= r_rd;
        res_data  <= alu_f;
      end
      // Writeback is ordered after the load so it wins on an address clash.
      if (ld_en) r_regs[ld_addr] <= ld_data;
      if (w_wb)  r_regs[res_rd]  <= res_data;
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: table vectors, handshake/load/reset corner cases,
// opcode sweep and randomized instructions checked against an array-based register model.
module tb_alu_operand_sequencer;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned NREG    = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned INSTR_W = 13;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [OP_W-1:0]    alu_op;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_f;
  logic               res_valid;
  logic [AW-1:0]      res_rd;
  logic [DATA_W-1:0]  res_data;
  logic               ld_en;
  logic [AW-1:0]      ld_addr;
  logic [DATA_W-1:0]  ld_data;
  logic [AW-1:0]      dbg_addr;
  logic [DATA_W-1:0]  dbg_data;

  always #5 clk = ~clk;

  // ALU stub: every opcode adds modulo 256.
  assign alu_f = 8'(alu_a + alu_b);

  alu_operand_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  logic [7:0] mdl [NREG];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    cyc();
    ld_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic check_all_regs(input string nm);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #0.1;
      chk(nm, 16'(dbg_data), 16'(mdl[i]));
    end
  endtask

  // One instruction from IDLE back to IDLE; optional load on the accept (1), EXEC (2) or WB (3) edge.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input int ld_ph, input logic [2:0] la,
                           input logic [7:0] ldd, input bit use_tbl, input logic [7:0] tbl_exp);
    logic [7:0] a, b, exp;
    a   = mdl[rs1];
    b   = mdl[rs2];
    exp = use_tbl ? tbl_exp : 8'(a + b);
    chk("idle_ready", 16'(in_ready), 16'd1);
    in_instr = {op, rd, rs1, rs2};
    in_valid = 1'b1;
    if (ld_ph == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
    cyc();
    in_valid = 1'b0; ld_en = 1'b0;
    if (ld_ph == 1) mdl[la] = ldd;
    if (ld_ph == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
    #1;
    chk("exec_op", 16'(alu_op), 16'(op));
    chk("exec_a", 16'(alu_a), 16'(a));
    chk("exec_b", 16'(alu_b), 16'(b));
    chk("exec_ready", 16'(in_ready), 16'd0);
    chk("exec_resv", 16'(res_valid), 16'd0);
    cyc();
    ld_en = 1'b0;
    if (ld_ph == 2) mdl[la] = ldd;
    if (ld_ph == 3) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
    #1;
    chk("wb_resv", 16'(res_valid), 16'd1);
    chk("wb_rd", 16'(res_rd), 16'(rd));
    chk("wb_data", 16'(res_data), 16'(exp));
    chk("wb_ready", 16'(in_ready), 16'd0);
    cyc();
    ld_en = 1'b0;
    if (ld_ph == 3) mdl[la] = ldd;
    mdl[rd] = exp;
    dbg_addr = rd;
    #1;
    chk("post_dbg_rd", 16'(dbg_data), 16'(mdl[rd]));
    chk("post_resv", 16'(res_valid), 16'd0);
    chk("post_hold_data", 16'(res_data), 16'(exp));
    chk("post_hold_rd", 16'(res_rd), 16'(rd));
    chk("post_hold_a", 16'(alu_a), 16'(a));
    if (ld_ph != 0) begin
      dbg_addr = la;
      #1;
      chk("post_dbg_ld", 16'(dbg_data), 16'(mdl[la]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [INSTR_W-1:0] words [3];
    logic [2:0]         exp_rd [3];
    logic [7:0]         exp_d [3];
    int                 pat [7];
    int                 idx, pulses;
    bit                 acc;
    logic [3:0]         r_op;
    logic [2:0]         r_rd, r_s1, r_s2, r_la;
    logic [7:0]         r_d;

    vecs[0] = '{a_val: 8'h12, b_val: 8'h34, op: 4'h0, rd: 3'd3, rs1: 3'd1, rs2: 3'd2, exp_data: 8'h46};
    vecs[1] = '{a_val: 8'hF0, b_val: 8'h20, op: 4'h1, rd: 3'd1, rs1: 3'd1, rs2: 3'd2, exp_data: 8'h10};
    vecs[2] = '{a_val: 8'h80, b_val: 8'h80, op: 4'h5, rd: 3'd6, rs1: 3'd5, rs2: 3'd5, exp_data: 8'h00};
    vecs[3] = '{a_val: 8'hFF, b_val: 8'h01, op: 4'hF, rd: 3'd0, rs1: 3'd7, rs2: 3'd0, exp_data: 8'h00};
    vecs[4] = '{a_val: 8'h7F, b_val: 8'h01, op: 4'h9, rd: 3'd4, rs1: 3'd4, rs2: 3'd2, exp_data: 8'h80};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

    // Reset state
    cyc(); cyc();
    chk("rst_ready", 16'(in_ready), 16'd0);
    chk("rst_op", 16'(alu_op), 16'd0);
    chk("rst_a", 16'(alu_a), 16'd0);
    chk("rst_b", 16'(alu_b), 16'd0);
    chk("rst_resv", 16'(res_valid), 16'd0);
    chk("rst_rd", 16'(res_rd), 16'd0);
    chk("rst_data", 16'(res_data), 16'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", 16'(in_ready), 16'd1);
    check_all_regs("rst_regs");

    // Table-driven vectors
    for (int v = 0; v < 5; v++) begin
      load(vecs[v].rs1, vecs[v].a_val);
      load(vecs[v].rs2, vecs[v].b_val);
      run_instr(vecs[v].op, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, 0, 3'd0, 8'h00, 1'b1, vecs[v].exp_data);
      if (v == 1) begin
        dbg_addr = 3'd2;
        #1;
        chk("vec_src_unchanged", 16'(dbg_data), 16'h20);
      end
    end

    // Back-to-back with in_valid held high
    load(3'd1, 8'h11);
    words[0] = {4'h1, 3'd2, 3'd1, 3'd1}; exp_rd[0] = 3'd2; exp_d[0] = 8'h22;
    words[1] = {4'h2, 3'd3, 3'd2, 3'd1}; exp_rd[1] = 3'd3; exp_d[1] = 8'h33;
    words[2] = {4'h3, 3'd1, 3'd3, 3'd2}; exp_rd[2] = 3'd1; exp_d[2] = 8'h55;
    pat = '{1, 0, 0, 1, 0, 0, 1};
    idx = 0; pulses = 0;
    in_valid = 1'b1; in_instr = words[0];
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c < 7) chk("b2b_ready", 16'(in_ready), 16'(pat[c]));
      if (res_valid) begin
        if (pulses < 3) begin
          chk("b2b_rd", 16'(res_rd), 16'(exp_rd[pulses]));
          chk("b2b_data", 16'(res_data), 16'(exp_d[pulses]));
        end
        pulses++;
      end
      acc = in_ready && in_valid;
      cyc();
      if (acc) begin
        idx++;
        if (idx < 3) in_instr = words[idx];
        else         in_valid = 1'b0;
      end
    end
    chk("b2b_pulses", 16'(pulses), 16'd3);
    for (int i = 0; i < 3; i++) mdl[exp_rd[i]] = exp_d[i];
    check_all_regs("b2b_regs");

    // Load on the WB edge to the same rd: writeback wins
    load(3'd1, 8'h50); load(3'd2, 8'h05);
    run_instr(4'h4, 3'd3, 3'd1, 3'd2, 3, 3'd3, 8'hAA, 1'b1, 8'h55);
    dbg_addr = 3'd3; #1;
    chk("wb_wins", 16'(dbg_data), 16'h55);
    // Load on the WB edge to a different address: both land
    run_instr(4'h6, 3'd5, 3'd1, 3'd2, 3, 3'd6, 8'h3C, 1'b0, 8'h00);
    // Load during EXEC to a source: operands already captured
    load(3'd4, 8'h10); load(3'd1, 8'h01);
    run_instr(4'h7, 3'd2, 3'd4, 3'd1, 2, 3'd4, 8'h70, 1'b1, 8'h11);
    dbg_addr = 3'd4; #1;
    chk("exec_ld_r4", 16'(dbg_data), 16'h70);
    // Load on the accept edge to rs1: operand uses old value
    load(3'd1, 8'h03); load(3'd2, 8'h04);
    run_instr(4'h8, 3'd5, 3'd1, 3'd2, 1, 3'd1, 8'h99, 1'b1, 8'h07);

    // Reset during EXEC
    load(3'd1, 8'h21);
    in_instr = {4'hA, 3'd6, 3'd1, 3'd1}; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready_held", 16'(in_ready), 16'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    #1;
    chk("midrst_resv", 16'(res_valid), 16'd0);
    chk("midrst_op", 16'(alu_op), 16'd0);
    chk("midrst_a", 16'(alu_a), 16'd0);
    chk("midrst_b", 16'(alu_b), 16'd0);
    chk("midrst_ready", 16'(in_ready), 16'd1);
    check_all_regs("midrst_regs");
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("midrst_no_pulse", 16'(res_valid), 16'd0);
    end

    // Opcode sweep
    for (int o = 0; o < 16; o++) begin
      load(3'(o % 8), 8'($urandom_range(0, 255)));
      run_instr(4'(o), 3'((o + 3) % 8), 3'(o % 8), 3'((o + 1) % 8), 0, 3'd0, 8'h00, 1'b0, 8'h00);
    end

    // Randomized instructions against the register model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) load(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) cyc();
      r_op = 4'($urandom_range(0, 15));
      r_rd = 3'($urandom_range(0, 7));
      r_s1 = 3'($urandom_range(0, 7));
      r_s2 = 3'($urandom_range(0, 7));
      r_la = 3'($urandom_range(0, 7));
      r_d  = 8'($urandom_range(0, 255));
      run_instr(r_op, r_rd, r_s1, r_s2, int'($urandom_range(0, 3)), r_la, r_d, 1'b0, 8'h00);
      if (it % 10 == 9) check_all_regs("rand_regs");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
